kovacs_sequencer: RTL

KOVACS_SEQUENCER -- requirements
Module: kovacs_sequencer

---
 rtl/kovacs_sequencer.sv | 109 ++++++++++
 1 files changed

// File: rtl/kovacs_sequencer.sv
// kovacs_sequencer: phase-timed protocol sequencer routing a truncated sample to one of two DAC channels
module kovacs_sequencer #(
    parameter int N_PHASES = 4,
    parameter int DIN_W = 16,
    parameter int DOUT_W = 14,
    parameter int CNT_W = 32,
    parameter logic [DOUT_W-1:0] IND_HIGH = 14'h1FFF
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         stop_i,
    input  logic                         mode_i,
    input  logic [DIN_W-1:0]             data_i,
    input  logic [N_PHASES*CNT_W-1:0]    dur_i,
    input  logic [N_PHASES-1:0]          route_i,
    output logic [DOUT_W-1:0]            data0_o,
    output logic [DOUT_W-1:0]            data1_o,
    output logic [DOUT_W-1:0]            indicator0_o,
    output logic [DOUT_W-1:0]            indicator1_o,
    output logic [$clog2(N_PHASES)-1:0]  phase_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [CNT_W-1:0]             cycles_o
);
    localparam int PH_W = $clog2(N_PHASES);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, nxt_state;
    logic [CNT_W-1:0] dur_q [N_PHASES];
    logic [N_PHASES-1:0] route_q, nxt_route;
    logic mode_q, latch, ph_end, last_ph, nxt_done, sel, nxt_run;
    logic [PH_W-1:0] nxt_phase;
    logic [CNT_W-1:0] cnt, nxt_cnt, nxt_cycles, cur_dur;
    logic [DOUT_W-1:0] sample;
    // A zero duration behaves as a single-cycle phase
    assign cur_dur = dur_q[phase_o];
    assign ph_end = cnt == ((cur_dur == '0) ? '0 : cur_dur - CNT_W'(1));
    assign last_ph = phase_o == PH_W'(N_PHASES - 1);
    assign sample = DOUT_W'(data_i >> (DIN_W - DOUT_W));
    assign nxt_route = latch ? route_i : route_q;
    assign nxt_run = nxt_state == RUN;
    assign sel = nxt_route[nxt_phase];
    assign busy_o = state == RUN;
    always_comb begin
        nxt_state = state;
        nxt_phase = phase_o;
        nxt_cnt = cnt;
        nxt_cycles = cycles_o;
        nxt_done = 1'b0;
        latch = 1'b0;
        if (state == IDLE) begin
            if (start_i && !stop_i) begin
                nxt_state = RUN;
                latch = 1'b1;
                nxt_phase = '0;
                nxt_cnt = '0;
                nxt_cycles = '0;
            end
        end else if (stop_i) begin
            nxt_state = IDLE;
            nxt_phase = '0;
            nxt_cnt = '0;
        end else if (!ph_end) begin
            nxt_cnt = cnt + CNT_W'(1);
        end else begin
            nxt_cnt = '0;
            nxt_phase = last_ph ? '0 : phase_o + PH_W'(1);
            if (last_ph && mode_q) begin
                nxt_cycles = cycles_o + CNT_W'(1);
                latch = 1'b1;
            end else if (last_ph) begin
                nxt_state = IDLE;
                nxt_done = 1'b1;
            end
        end
    end
    // Outputs are derived from the next state so sample, routing and phase move together
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt <= '0;
            phase_o <= '0;
            cycles_o <= '0;
            done_o <= 1'b0;
            route_q <= '0;
            mode_q <= 1'b0;
            for (int k = 0; k < N_PHASES; k++) dur_q[k] <= '0;
            data0_o <= '0;
            data1_o <= '0;
            indicator0_o <= '0;
            indicator1_o <= '0;
        end else begin
            state <= nxt_state;
            cnt <= nxt_cnt;
            phase_o <= nxt_phase;
            cycles_o <= nxt_cycles;
            done_o <= nxt_done;
            if (latch) begin
                route_q <= route_i;
                mode_q <= mode_i;
                for (int k = 0; k < N_PHASES; k++) dur_q[k] <= dur_i[k*CNT_W +: CNT_W];
            end
            data0_o <= (nxt_run && !sel) ? sample : '0;
            data1_o <= (nxt_run && sel) ? sample : '0;
            indicator0_o <= (nxt_run && !sel) ? IND_HIGH : '0;
            indicator1_o <= (nxt_run && sel) ? IND_HIGH : '0;
        end
    end
endmodule
